// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with burst lock; grant is combinational from req_i (zero latency).
// State (pointer, lock, owner) moves only on valid_o & ready_i; ready_i never reaches the grant path.
module rr_lock_arbiter #(
    parameter int N_REQ   = 4,
    parameter int PTR_W   = $clog2(N_REQ),
    parameter int MODE    = 1,
    parameter int LOCK_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             lock_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic [PTR_W-1:0] rr_flag_o,
    output logic             locked_o
);

    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_EXT = (PTR_W + 1)'(N_REQ);

    logic [PTR_W-1:0] rr_flag_q;
    logic             lock_q;
    logic [PTR_W-1:0] owner_q;

    logic [N_REQ-1:0] req_rot;
    logic [PTR_W-1:0] rot_pos;
    logic [PTR_W:0]   rr_sum;
    logic [PTR_W-1:0] rr_idx;
    logic             eff_lock;
    logic [PTR_W-1:0] gnt_idx;
    logic             xfer;
    logic             ptr_adv;
    logic [PTR_W-1:0] rr_flag_d;

    // Rotate requests so the pointer position lands on bit 0, then take the lowest set bit.
    always_comb begin
        req_rot = N_REQ'({req_i, req_i} >> rr_flag_q);
        rot_pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_pos = PTR_W'(i);
            end
        end
        rr_sum = {1'b0, rr_flag_q} + {1'b0, rot_pos};
        if (rr_sum >= N_EXT) begin
            rr_idx = PTR_W'(rr_sum - N_EXT);
        end else begin
            rr_idx = rr_sum[PTR_W-1:0];
        end
    end

    assign eff_lock  = (LOCK_EN != 0) && lock_q && req_i[owner_q];
    assign valid_o   = |req_i;
    assign gnt_idx   = eff_lock ? owner_q : rr_idx;
    assign gnt_idx_o = valid_o ? gnt_idx : '0;
    assign gnt_o     = valid_o ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    assign xfer = valid_o & ready_i;

    // A locked beat that keeps the lock freezes the pointer; the releasing beat advances it.
    assign ptr_adv = xfer && !(eff_lock && lock_i);

    always_comb begin
        rr_flag_d = rr_flag_q;
        if (MODE == 0) begin
            rr_flag_d = (rr_flag_q == LAST) ? '0 : rr_flag_q + 1'b1;
        end else begin
            rr_flag_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_flag_q <= '0;
        end else if (ptr_adv) begin
            rr_flag_q <= rr_flag_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (LOCK_EN == 0) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (xfer) begin
            lock_q <= lock_i;
            if (lock_i) begin
                owner_q <= gnt_idx;
            end
        end else if (lock_q && !req_i[owner_q]) begin
            // Owner walked away mid-burst without a transfer: release so the lock cannot go stale.
            lock_q <= 1'b0;
        end
    end

    assign rr_flag_o = rr_flag_q;
    assign locked_o  = lock_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: 4-way grant-follow with lock, plus 3-way counter mode.
module tb_rr_lock_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       lock;
    logic       ready;
    logic       valid;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic [1:0] rr;
    logic       locked;

    logic [2:0] req3;
    logic       lock3;
    logic       ready3;
    logic       valid3;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic [1:0] rr3;
    logic       locked3;

    int n_tests;
    int n_fail;

    rr_lock_arbiter #(.N_REQ(4), .MODE(1), .LOCK_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .ready_i(ready),
        .valid_o(valid), .gnt_o(gnt), .gnt_idx_o(idx), .rr_flag_o(rr), .locked_o(locked)
    );

    rr_lock_arbiter #(.N_REQ(3), .MODE(0), .LOCK_EN(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .lock_i(lock3), .ready_i(ready3),
        .valid_o(valid3), .gnt_o(gnt3), .gnt_idx_o(idx3), .rr_flag_o(rr3), .locked_o(locked3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; req = 4'b0; lock = 1'b0; ready = 1'b0;
        req3 = 3'b0; lock3 = 1'b0; ready3 = 1'b0;

        // reset state
        #2;
        chk("rst_valid", valid, 1'b0);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_idx", idx, 2'd0);
        chk("rst_rr", rr, 2'd0);
        chk("rst_locked", locked, 1'b0);
        req = 4'b1111;
        #1;
        chk("rst_gnt_lowest", gnt, 4'b0001);
        cyc();
        chk("rst_hold_rr", rr, 2'd0);
        rst_n = 1'b1;

        // full load, grant-follow
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t1_idx", idx, 32'(i % 4));
            chk("t1_gnt", gnt, 32'(1 << (i % 4)));
            cyc();
            chk("t1_rr", rr, 32'((i + 1) % 4));
        end

        // 3-way counter mode; DUT4 idle meanwhile
        req = 4'b0000;
        req3 = 3'b111;
        ready3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("n3_idx", idx3, 32'(i % 3));
            cyc();
            chk("n3_rr", rr3, 32'((i + 1) % 3));
        end
        req3 = 3'b000;
        ready3 = 1'b0;
        chk("idle_rr_static", rr, 2'd0);

        // sparse requests
        req = 4'b0001;
        #1; chk("sp_idx0", idx, 2'd0);
        cyc(); chk("sp_rr0", rr, 2'd1);
        req = 4'b1001;
        #1; chk("sp_idx1", idx, 2'd3);
        cyc(); chk("sp_rr1", rr, 2'd0);
        #1; chk("sp_idx2", idx, 2'd0);
        cyc(); chk("sp_rr2", rr, 2'd1);
        #1; chk("sp_idx3", idx, 2'd3);
        cyc(); chk("sp_rr3", rr, 2'd0);

        // stall
        req = 4'b0110;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; chk("st_gnt", gnt, 4'b0010);
            cyc(); chk("st_rr", rr, 2'd0);
        end
        ready = 1'b1;
        #1; chk("st_gnt_go", gnt, 4'b0010);
        cyc(); chk("st_rr_go", rr, 2'd2);
        #1; chk("st_gnt_next", gnt, 4'b0100);
        cyc(); chk("st_rr_next", rr, 2'd3);

        // bring pointer to 2
        req = 4'b0010;
        #1; chk("pre_idx", idx, 2'd1);
        cyc(); chk("pre_rr", rr, 2'd2);

        // lock burst by owner 2
        req = 4'b1111;
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("lk_idx", idx, 2'd2);
            cyc();
            chk("lk_locked", locked, 1'b1);
            chk("lk_rr", rr, 2'd3);
        end
        lock = 1'b0;
        #1; chk("lk_rel_idx", idx, 2'd2);
        cyc();
        chk("lk_rel_locked", locked, 1'b0);
        chk("lk_rel_rr", rr, 2'd3);
        #1; chk("lk_after_idx", idx, 2'd3);
        cyc(); chk("lk_after_rr", rr, 2'd0);

        // owner drops while locked
        req = 4'b0100;
        lock = 1'b1;
        #1; chk("dr_idx", idx, 2'd2);
        cyc();
        chk("dr_locked", locked, 1'b1);
        chk("dr_rr", rr, 2'd3);
        req = 4'b1011;
        lock = 1'b0;
        ready = 1'b0;
        #1;
        chk("dr_gnt_same", gnt, 4'b1000);
        chk("dr_locked_pre", locked, 1'b1);
        cyc();
        chk("dr_locked_post", locked, 1'b0);
        chk("dr_rr_post", rr, 2'd3);
        chk("dr_gnt_post", gnt, 4'b1000);

        // async reset mid-lock
        req = 4'b0001;
        lock = 1'b1;
        ready = 1'b1;
        #1; chk("ar_idx", idx, 2'd0);
        cyc();
        chk("ar_locked", locked, 1'b1);
        chk("ar_rr", rr, 2'd1);
        ready = 1'b0;
        lock = 1'b0;
        req = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_locked_rst", locked, 1'b0);
        chk("ar_rr_rst", rr, 2'd0);
        chk("ar_gnt_rst", gnt, 4'b0010);
        chk("ar_rr3_rst", rr3, 2'd0);
        cyc();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Parametrised N-way round-robin arbiter for the icache multi-port interconnect, generalising the single-counter RR flag generator. It holds the round-robin priority pointer, computes a fair one-hot grant among `N_REQ` requesters, and updates state only on a completed transfer, so the flop stays static, and clock-gateable, when idle. It adds grant-follow pointer update, support for non-power-of-two requester counts, and a lock mode that holds ownership across multi-beat bursts. It sits between the per-port request lines and a shared SCM bank or refill port.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2 to 64, powers of two not required.
- `PTR_W`, default `$clog2(N_REQ)`: width of the pointer and index outputs.
- `MODE`, default 1: pointer update policy.
  - 0 = counter: pointer +1 on each transfer.
  - 1 = grant-follow: pointer = granted index + 1.
- `LOCK_EN`, default 1: 1 enables the `lock_i` burst hold; 0 ties the lock logic off.
- Ports:
  - `clk`, in, 1: clock.
  - `rst_n`, in, 1: reset, asynchronous, active-low.
  - `req_i`, in, `N_REQ`: per-requester request, level.
  - `lock_i`, in, 1: hold the current owner after this transfer.
  - `ready_i`, in, 1: downstream accepts the granted request.
  - `valid_o`, out, 1: some request is granted.
  - `gnt_o`, out, `N_REQ`: one-hot grant, all zero when `valid_o` = 0.
  - `gnt_idx_o`, out, `PTR_W`: binary index of the granted requester.
  - `rr_flag_o`, out, `PTR_W`: current priority pointer, registered.
  - `locked_o`, out, 1: lock register state, registered.

## Operation
- Registered state: `rr_flag_q`, `lock_q`, `owner_q`. Reset values: all 0.
  - Outputs under reset: `rr_flag_o` = 0, `locked_o` = 0.
  - Outputs under reset follow the combinational rules with pointer 0: `gnt_o` = lowest-index requester, or all zero if none.
- Effective lock: `eff_lock = lock_q & req_i[owner_q]`.
- Grant selection, combinational:
  - If `eff_lock` is 1, grant `owner_q` and ignore all other requests.
  - Otherwise, grant the first requester with `req_i` set, scanning cyclically from index `rr_flag_q` upward and wrapping from `N_REQ-1` to 0.
- `valid_o = |req_i`. `gnt_idx_o` is the encoded form of `gnt_o`; it is 0 when `valid_o` = 0.
- Transfer: `valid_o & ready_i`. All state updates happen only on a transfer, except lock release (below).
- Pointer update on a transfer with no effective lock:
  - MODE 0: `rr_flag_q <= (rr_flag_q == N_REQ-1) ? 0 : rr_flag_q + 1`.
  - MODE 1: `rr_flag_q <= (gnt_idx == N_REQ-1) ? 0 : gnt_idx + 1`.
- The pointer is frozen during locked transfers. It advances on the transfer that releases the lock.
- Lock, when `LOCK_EN` = 1:
  - A transfer with `lock_i` = 1 sets `lock_q <= 1` and `owner_q <= gnt_idx`.
  - A transfer with `lock_i` = 0 clears `lock_q`.
  - If `lock_q` = 1 and `req_i[owner_q]` = 0, arbitration falls back to normal in the same cycle, and `lock_q` clears at the next edge even without a transfer.
- `LOCK_EN` = 0: `lock_q` is constant 0 and `lock_i` is ignored.
- Pointer arithmetic stays in `PTR_W` bits. The pointer never holds a value ≥ `N_REQ`.
- Requesters must hold `req_i` until granted with `ready_i`. While `ready_i` = 0 and `req_i` is unchanged, the grant is stable.

## Timing
- Arbitration latency is zero cycles: `req_i` to `gnt_o`/`valid_o` is combinational.
- `ready_i` feeds state only. There is no combinational path from `ready_i` to `gnt_o`.
- Pointer, lock and owner updates are visible in the cycle after the transfer edge.
- Simultaneous events:
  - New requests arriving in the transfer cycle are arbitrated against the updated pointer in the next cycle.
  - Owner drop coincident with other requests: the other requests are arbitrated in the same cycle with the current pointer.
- Reset asserted mid-burst clears the lock and pointer immediately (asynchronous). Arbitration restarts from index 0.

## Test plan
- Reset, N_REQ=4, MODE=1, `req_i`=4'b1111, `ready_i`=1 for 8 cycles:
  - grant sequence 0,1,2,3,0,1,2,3;
  - `rr_flag_o` sequence 1,2,3,0,...
- N_REQ=3 (non-power-of-two), MODE=0, `req_i`=3'b111, `ready_i`=1 for 7 transfers:
  - `rr_flag_o` 1,2,0,1,2,0,1;
  - never reaches 3.
- MODE=1 sparse requests, `req_i`=4'b1001, `rr_flag`=1: grant index 3 → pointer 0, then grant index 0 → pointer 1, then grant index 3 again.
- Stall: `req_i`=4'b0110, `ready_i`=0 for 5 cycles:
  - `gnt_o` stays 4'b0010;
  - `rr_flag_o` is unchanged.
  - Then `ready_i`=1 for one cycle: pointer becomes 2 and the next grant is 4'b0100.
- Lock: owner 2 transfers with `lock_i`=1 for 3 beats while `req_i`=4'b1111:
  - grant stays on index 2 and `locked_o`=1;
  - on a beat with `lock_i`=0, the lock clears and the next grant is index 3.
  - Repeat with owner 2 dropping `req_i` while locked: another requester is granted the same cycle and `locked_o`=0 after the edge.
- Async reset mid-lock: assert `rst_n`=0 between edges; `locked_o`=0 and `rr_flag_o`=0 immediately, before the next edge.
